// File: rtl/adder_pkg.sv
// Shared definitions for the adder_accumulator slice.
//   state_t          : packet FSM encoding (IDLE, ACC, DONE)
//   DEF_WIDTH        : default operand width
//   MAX_INT/MIN_INT  : signed clamp limits at DEF_WIDTH
//   max_int/min_int  : clamp limits for any width up to 64
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [DEF_WIDTH-1:0] MAX_INT = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] MIN_INT = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    // Clamp limits for an arbitrary width. Only the low w bits of the
    // result are meaningful; the caller truncates to its own width.
    function automatic logic [63:0] max_int(input int unsigned w);
        max_int = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_int(input int unsigned w);
        min_int = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/bypassAdder.sv
// Carry-bypass (carry-skip) adder.
//   A, B     : operands
//   Cin      : carry in
//   S        : sum, modulo 2^WIDTH
//   Cout     : carry out of the MSB
//   overFlow : signed overflow (A and B have the same sign, S does not)
// Carries ripple inside blocks of BLK bits. When every bit of a block
// propagates, the block's carry-in is forwarded straight to its carry-out.
// The whole chain is evaluated in one combinational process with local
// variables, so no net feeds back into itself.
module bypassAdder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overFlow
);

    always_comb begin
        logic c;
        logic c_blk;
        logic p;
        logic all_p;
        S     = '0;
        c     = Cin;
        c_blk = Cin;
        all_p = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i % BLK == 0) begin
                c_blk = c;
                all_p = 1'b1;
            end
            p     = A[i] ^ B[i];
            S[i]  = p ^ c;
            c     = (A[i] & B[i]) | (p & c);
            all_p = all_p & p;
            // Last bit of a block: take the skip path if the block propagates.
            if ((i % BLK == BLK - 1) || (i == WIDTH - 1))
                c = all_p ? c_blk : c;
        end
        Cout     = c;
        overFlow = (A[WIDTH-1] == B[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
    end

endmodule

// File: rtl/adder_accumulator.sv
// Streaming signed accumulator.
// Each beat accepted on the input channel is added into a running sum
// through one bypassAdder. The packet total, a sticky signed-overflow
// flag, the carry-out of the final add and a saturating beat count are
// presented on the output channel once the beat marked inLast is accepted.
//   clk, rst                          : clock, asynchronous active-high reset
//   inValid/inReady/inData/inLast     : operand stream
//   outValid/outReady                 : result handshake
//   outSum/outOverflow/outCarry/outCount : packet result
// Build option: define ACC_SATURATE_EN to clamp the running sum to the
// signed limits when an add overflows. Without it the sum wraps.
module adder_accumulator
    import adder_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    output logic               inReady,
    input  logic [WIDTH-1:0]   inData,
    input  logic               inLast,
    output logic               outValid,
    input  logic               outReady,
    output logic [WIDTH-1:0]   outSum,
    output logic               outOverflow,
    output logic               outCarry,
    output logic [COUNT_W-1:0] outCount
);

    state_t               state, nxt;
    logic [WIDTH-1:0]     acc, sum, acc_nxt;
    logic                 ovf, carry, cout, add_ovf;
    logic [COUNT_W-1:0]   count;
    logic                 beat, drain;

    assign inReady = (state != DONE);
    assign outValid = (state == DONE);
    assign beat    = inValid & inReady;
    assign drain   = outValid & outReady;

    bypassAdder #(.WIDTH(WIDTH)) u_add (
        .A        (acc),
        .B        (inData),
        .Cin      (1'b0),
        .S        (sum),
        .Cout     (cout),
        .overFlow (add_ovf)
    );

`ifdef ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(max_int(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(min_int(WIDTH));

    // An overflowing add always has operands of equal sign, so the sign
    // of inData picks the limit the true sum ran past.
    assign acc_nxt = add_ovf ? (inData[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign acc_nxt = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, ACC: if (beat) nxt = inLast ? DONE : ACC;
            DONE:      if (drain) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            count <= '0;
        end else if (beat) begin
            acc   <= acc_nxt;
            ovf   <= ovf | add_ovf;
            carry <= cout;
            if (count != '1) count <= count + 1'b1;
        end else if (drain) begin
            acc   <= '0;
            ovf   <= 1'b0;
            carry <= 1'b0;
            count <= '0;
        end
    end

    assign outSum      = acc;
    assign outOverflow = ovf;
    assign outCarry    = carry;
    assign outCount    = count;

endmodule

// File: tb/tb_adder_accumulator.sv
module tb_adder_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inData = '0;
    logic        inLast = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] outSum;
    logic        outOverflow;
    logic        outCarry;
    logic [7:0]  outCount;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic        carry;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.WIDTH(32), .COUNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .inValid     (inValid),
        .inReady     (inReady),
        .inData      (inData),
        .inLast      (inLast),
        .outValid    (outValid),
        .outReady    (outReady),
        .outSum      (outSum),
        .outOverflow (outOverflow),
        .outCarry    (outCarry),
        .outCount    (outCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic expect_pkt(input logic [31:0] s, input logic o, input logic c, input logic [7:0] n);
        exp_t e;
        e.sum = s; e.ovf = o; e.carry = c; e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: a result is consumed on the edge following a negedge
    // where outValid & outReady are both high.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("outSum",      outSum,             e.sum);
                check("outOverflow", 32'(outOverflow),   32'(e.ovf));
                check("outCarry",    32'(outCarry),      32'(e.carry));
                check("outCount",    32'(outCount),      32'(e.cnt));
            end
        end
    end

    // Offer one beat; returns #1 after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic last);
        bit ok = 0;
        inValid = 1'b1; inData = d; inLast = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (inReady) begin
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd1, 32'd0);
        inValid = 1'b0; inLast = 1'b0;
        if (ok && last) begin
            @(negedge clk);
            check("latency_outValid", 32'(outValid), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // reset state
        #1;
        check("rst_outValid", 32'(outValid), 32'd0);
        check("rst_outSum",   outSum,        32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_inReady",  32'(inReady),     32'd1);
        check("rst_outOvf",   32'(outOverflow), 32'd0);
        check("rst_outCarry", 32'(outCarry),    32'd0);
        check("rst_outCount", 32'(outCount),    32'd0);
        @(posedge clk); #1;

        // {10, -5}
        expect_pkt(32'd5, 1'b0, 1'b1, 8'd2);
        send(32'd10, 1'b0);
        send(-32'sd5, 1'b1);

        // {MAX, 1, -1}
`ifdef ACC_SATURATE_EN
        expect_pkt(32'h7FFF_FFFE, 1'b1, 1'b1, 8'd3);
`else
        expect_pkt(32'h7FFF_FFFF, 1'b1, 1'b1, 8'd3);
`endif
        send(32'h7FFF_FFFF, 1'b0);
        send(32'd1, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);

        // {MIN, -5}
`ifdef ACC_SATURATE_EN
        expect_pkt(32'h8000_0000, 1'b1, 1'b1, 8'd2);
`else
        expect_pkt(32'h7FFF_FFFB, 1'b1, 1'b1, 8'd2);
`endif
        send(32'h8000_0000, 1'b0);
        send(-32'sd5, 1'b1);

        // backpressure on {5, 5}; a beat offered while DONE must be ignored
        outReady = 1'b0;
        send(32'd5, 1'b0);
        send(32'd5, 1'b1);
        inValid = 1'b1; inData = 32'd1000; inLast = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_outValid", 32'(outValid), 32'd1);
            check("hold_outSum",   outSum,        32'd10);
            check("hold_inReady",  32'(inReady),  32'd0);
        end
        @(posedge clk); #1;
        inValid = 1'b0; inLast = 1'b0;
        expect_pkt(32'd10, 1'b0, 1'b0, 8'd2);
        outReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_inReady", 32'(inReady), 32'd1);
        check("drain_outSum",  outSum,       32'd0);
        @(posedge clk); #1;

        // {-5, -5}
        expect_pkt(32'hFFFF_FFF6, 1'b0, 1'b1, 8'd2);
        send(-32'sd5, 1'b0);
        send(-32'sd5, 1'b1);

        // reset mid-packet
        send(32'd7, 1'b0);
        send(32'd8, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_outSum",   outSum,         32'd0);
        check("midrst_outCount", 32'(outCount),  32'd0);
        check("midrst_outValid", 32'(outValid),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        expect_pkt(32'd3, 1'b0, 1'b0, 8'd1);
        send(32'd3, 1'b1);

        // count saturation: 260 beats of 1
        expect_pkt(32'd260, 1'b0, 1'b0, 8'd255);
        for (int i = 0; i < 260; i++) send(32'd1, i == 259);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) check("results_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
- Streaming signed accumulator built around the existing 32-bit bypassAdder.
- Accepts a packet of operands over a valid/ready input and adds each one into a running sum.
- Raises a sticky overflow flag if any add in the packet overflows.
- Presents the packet total on a valid/ready output. It is the sequential stage that feeds the adder and consumes its S/Cout/overFlow outputs.

Parameters:
- WIDTH, 32, operand and sum width in bits (two's complement).
- COUNT_W, 8, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- inValid  in  1  operand beat valid
- inReady  out  1  block can accept a beat
- inData  in  WIDTH  signed operand
- inLast  in  1  marks the final beat of a packet
- outValid  out  1  packet result valid
- outReady  in  1  downstream accepts the result
- outSum  out  WIDTH  accumulated sum
- outOverflow  out  1  sticky signed overflow over the packet
- outCarry  out  1  Cout of the last add in the packet
- outCount  out  COUNT_W  beats accepted in the packet (saturating)

Behaviour:
- Reset (async, rst=1):
  - acc=0, ovf=0, carry=0, count=0, state=IDLE.
  - Outputs: outValid=0, inReady=1 after rst deasserts, outSum=0, outOverflow=0, outCarry=0, outCount=0.
- States:
  - IDLE: no beat accepted yet in this packet.
  - ACC: at least one beat accepted, inLast not yet seen.
  - DONE: result held on the output.
- inReady = 1 in IDLE and ACC, 0 in DONE.
- A beat is accepted when inValid & inReady. On each accepted beat:
  - The adder computes A=acc, B=inData, Cin=0.
  - acc <= S; ovf <= ovf | overFlow; carry <= Cout.
  - count <= count+1, saturating at 2^COUNT_W-1.
- Transitions:
  - IDLE to ACC on an accepted beat with inLast=0.
  - IDLE or ACC to DONE on an accepted beat with inLast=1.
  - A single-beat packet is legal: sum = inData, ovf = 0.
- Latency: outValid rises the cycle after the inLast beat is accepted. outSum/outOverflow/outCarry/outCount drive acc/ovf/carry/count directly.
- DONE:
  - Outputs are held stable while outValid=1 and outReady=0.
  - On outValid & outReady: acc, ovf, carry and count clear to 0; state goes to IDLE.
  - inReady returns to 1 the next cycle (no same-cycle accept of a new beat).
- inValid in DONE is ignored. Upstream must hold its beat until inReady.
- outReady outside DONE has no effect.
- Arithmetic: signed two's complement. Overflow is taken only from the adder's overFlow (operands same sign, result different). Without saturation the sum wraps modulo 2^WIDTH.
- Reset mid-packet discards the partial sum. No result is emitted.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: when an add overflows, acc loads the clamp value instead of S.
  - Clamp is MAX_INT (2^(WIDTH-1)-1) if inData is non-negative, else MIN_INT (-2^(WIDTH-1)).
  - ovf is still set.
  - Later beats add to the clamped value.
- Undefined: acc wraps, giving bit-exact adder S.

Decomposition:
- Shared package adder_pkg holds:
  - the state encoding (IDLE, ACC, DONE) as a 2-bit typedef;
  - the MAX_INT and MIN_INT constants for WIDTH.
- Sub-module: one instance of the existing bypassAdder. No new sub-module.

Test Plan:
- Packet {10, -5 last} -> outSum=5, outOverflow=0, outCount=2, outValid one cycle after the last beat.
- Packet {2147483647, 1, -1 last}, macro off -> wraps to minInt then back; outSum=2147483647, outOverflow=1 (sticky).
- Same packet with ACC_SATURATE_EN -> clamps at 2147483647, then 2147483646; outSum=2147483646, outOverflow=1.
- Packet {-2147483648, -5 last}, macro off -> outSum=2147483643, outOverflow=1, outCarry=1.
- Backpressure: result of {5, 5 last} with outReady=0 for 4 cycles -> outSum=10 held stable, inReady=0 throughout; outReady=1 -> IDLE, next packet {-5, -5 last} gives -10 with count=2.
- Assert rst after 2 beats of {7, 8, ...} -> all outputs 0 immediately; next packet {3 last} gives outSum=3, outCount=1.
